// File: rtl/fft_frame_reader.sv
// rtl/fft_frame_reader.sv - polls an FFT readout window and streams each new frame
//
// Purpose: polls the 32-bit frame counter at byte addresses 0..3 of a byte-wide
// readout window. When the counter differs from the last frame fetched (or no
// frame has been fetched since reset), it reads NUM_WORDS little-endian words
// starting at byte 4 and presents them one at a time on a valid/ready stream.
// chipselect stays high from the counter poll through the last word so the
// slave keeps the frame snapshot frozen.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   enable              1 = keep polling and fetching frames
//   chipselect          slave select (slave buffer frozen while 1)
//   address             byte address to slave
//   write, writedata    tied 0
//   readdata            slave data, valid one cycle after address
//   word_data           assembled word (byte at 4+4k+j in bits [8j+7:8j])
//   word_index          word number k within the frame
//   word_valid          word_data/word_index valid
//   word_ready          downstream accepts
//   frame_time          counter value of the frame being or last fetched
//   frame_done          one-cycle pulse in the cycle after the last word transfers
//   busy                1 in every state except IDLE
module fft_frame_reader #(
    parameter int NUM_WORDS = 128,
    parameter int POLL_GAP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        chipselect,
    output logic [15:0] address,
    output logic        write,
    output logic [7:0]  writedata,
    input  logic [7:0]  readdata,
    output logic [31:0] word_data,
    output logic [7:0]  word_index,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] frame_time,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_CNT,
        S_CMP,
        S_FETCH,
        S_EMIT
    } state_t;

    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
    localparam logic [7:0]  K_LAST   = 8'(NUM_WORDS - 1);

    state_t      state_q, state_d;
    logic [15:0] step_q, step_d;        // gap counter in GAP, issue/drain step in CNT/FETCH
    logic [7:0]  k_q, k_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] cnt_tmp_q, cnt_tmp_d;
    logic [31:0] data_q, data_d;
    logic [31:0] frame_time_q, frame_time_d;
    logic [31:0] last_time_q, last_time_d;
    logic        first_frame_q, first_frame_d;
    logic        frame_done_q, frame_done_d;

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        k_d           = k_q;
        addr_d        = addr_q;
        cnt_tmp_d     = cnt_tmp_q;
        data_d        = data_q;
        frame_time_d  = frame_time_q;
        last_time_d   = last_time_q;
        first_frame_d = first_frame_q;
        frame_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_GAP;
                    step_d  = '0;
                end
            end
            S_GAP: begin
                if (step_q == GAP_LAST) begin
                    state_d = S_CNT;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 16'd1;
                end
            end
            S_CNT: begin
                // Bytes arrive in address order; shifting right leaves byte 0 in [7:0].
                if (step_q != 16'd0) cnt_tmp_d = {readdata, cnt_tmp_q[31:8]};
                if (step_q == 16'd4) state_d = S_CMP;
                else                 step_d  = step_q + 16'd1;
            end
            S_CMP: begin
                step_d = '0;
                if (first_frame_q || (cnt_tmp_q != last_time_q)) begin
                    frame_time_d = cnt_tmp_q;
                    k_d          = '0;
                    state_d      = S_FETCH;
                end else begin
                    state_d = enable ? S_GAP : S_IDLE;
                end
            end
            S_FETCH: begin
                if (step_q != 16'd0) data_d = {readdata, data_q[31:8]};
                if (step_q == 16'd4) state_d = S_EMIT;
                else                 step_d  = step_q + 16'd1;
            end
            S_EMIT: begin
                if (word_ready) begin
                    step_d = '0;
                    if (k_q == K_LAST) begin
                        frame_done_d  = 1'b1;
                        last_time_d   = frame_time_q;
                        first_frame_d = 1'b0;
                        state_d       = enable ? S_GAP : S_IDLE;
                    end else begin
                        k_d     = k_q + 8'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Address changes only on issue steps; drain, CMP and stalls hold the last value.
        if (state_d == S_CNT && step_d < 16'd4) begin
            addr_d = {14'd0, step_d[1:0]};
        end else if (state_d == S_FETCH && step_d < 16'd4) begin
            addr_d = 16'd4 + {6'd0, k_d, 2'b00} + {14'd0, step_d[1:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            step_q        <= '0;
            k_q           <= '0;
            addr_q        <= '0;
            cnt_tmp_q     <= '0;
            data_q        <= '0;
            frame_time_q  <= '0;
            last_time_q   <= '0;
            first_frame_q <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            k_q           <= k_d;
            addr_q        <= addr_d;
            cnt_tmp_q     <= cnt_tmp_d;
            data_q        <= data_d;
            frame_time_q  <= frame_time_d;
            last_time_q   <= last_time_d;
            first_frame_q <= first_frame_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign chipselect = (state_q == S_CNT) || (state_q == S_CMP) ||
                        (state_q == S_FETCH) || (state_q == S_EMIT);
    assign busy       = (state_q != S_IDLE);
    assign word_valid = (state_q == S_EMIT);
    assign address    = addr_q;
    assign word_data  = data_q;
    assign word_index = k_q;
    assign frame_time = frame_time_q;
    assign frame_done = frame_done_q;
    assign write      = 1'b0;
    assign writedata  = 8'd0;

endmodule

// File: tb/tb_fft_frame_reader.sv
// tb/tb_fft_frame_reader.sv - randomized self-checking bench for fft_frame_reader
module tb_fft_frame_reader;

    localparam int NW = 4;
    localparam int PG = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        chipselect;
    logic [15:0] address;
    logic        write;
    logic [7:0]  writedata;
    logic [7:0]  readdata = 8'd0;
    logic [31:0] word_data;
    logic [7:0]  word_index;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] frame_time;
    logic        frame_done;
    logic        busy;

    always #5 clk = ~clk;

    fft_frame_reader #(.NUM_WORDS(NW), .POLL_GAP(PG)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .chipselect (chipselect),
        .address    (address),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .word_data  (word_data),
        .word_index (word_index),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_time (frame_time),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // Slave: live contents change freely; the readable buffer refreshes only while deselected.
    logic [7:0] live_mem [0:1023];
    logic [7:0] buf_mem  [0:1023];

    always @(posedge clk) begin
        readdata <= buf_mem[address[9:0]];
        if (!chipselect) for (int i = 0; i < 1024; i++) buf_mem[i] <= live_mem[i];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor
    int          cyc = 0;
    int          cs_rise_cyc = 0, done_cyc = 0, done_cnt = 0;
    int          valid_cycles = 0, cs_low_cycles = 0, prop_viol = 0;
    logic [31:0] got_data [$];
    logic [7:0]  got_idx  [$];
    logic        cs_prev = 1'b0, pv = 1'b0, pr = 1'b0;
    logic [31:0] pd = '0;
    logic [7:0]  pi = '0;
    logic [15:0] pa = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (chipselect && !cs_prev) cs_rise_cyc = cyc;
            if (word_valid && word_ready) begin
                got_data.push_back(word_data);
                got_idx.push_back(word_index);
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (word_valid) valid_cycles++;
            if (!chipselect) cs_low_cycles++;
            if (pv && !pr && (!word_valid || word_data != pd || word_index != pi || address != pa))
                prop_viol++;
        end
        cs_prev = reset ? 1'b0 : chipselect;
        pv = reset ? 1'b0 : word_valid;
        pr = word_ready;
        pd = word_data;
        pi = word_index;
        pa = address;
    end

    // Reference model: the frame the slave should deliver is just its counter and word array.
    logic [31:0] exp_words [NW];
    logic [31:0] exp_time;

    task automatic set_frame(input logic [31:0] cnt, input logic fix_w0, input logic [31:0] w0);
        exp_time = cnt;
        for (int j = 0; j < 4; j++) live_mem[j] = cnt[8*j +: 8];
        for (int k = 0; k < NW; k++) begin
            exp_words[k] = (fix_w0 && k == 0) ? w0 : $urandom;
            for (int j = 0; j < 4; j++) live_mem[4 + 4*k + j] = exp_words[k][8*j +: 8];
        end
    endtask

    task automatic wait_done(input string tag, input logic rnd);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 3000) begin
            @(posedge clk); #1;
            if (rnd) word_ready = 1'($urandom_range(0, 1));
            n++;
        end
        word_ready = 1'b1;
        check({tag, "_done_count"}, 32'(done_cnt - start), 32'd1);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_nwords"}, 32'(got_data.size()), 32'(NW));
        for (int k = 0; k < NW && k < got_data.size(); k++) begin
            check($sformatf("%s_word%0d", tag, k), got_data[k], exp_words[k]);
            check($sformatf("%s_index%0d", tag, k), {24'd0, got_idx[k]}, 32'(k));
        end
        check({tag, "_frame_time"}, frame_time, exp_time);
        got_data.delete();
        got_idx.delete();
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_cs"}, {31'd0, chipselect}, 32'd0);
        check({tag, "_address"}, {16'd0, address}, 32'd0);
        check({tag, "_word_data"}, word_data, 32'd0);
        check({tag, "_word_index"}, {24'd0, word_index}, 32'd0);
        check({tag, "_word_valid"}, {31'd0, word_valid}, 32'd0);
        check({tag, "_frame_time"}, frame_time, 32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_write"}, {23'd0, write, writedata}, 32'd0);
    endtask

    initial begin
        logic [31:0] c;
        logic [15:0] sa;
        logic [31:0] sd;
        logic [7:0]  si;
        int          found;
        int          cs_drops;

        reset = 1'b1;
        enable = 1'b0;
        word_ready = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            live_mem[i] = 8'd0;
            buf_mem[i] = 8'd0;
        end

        // Reset behaviour
        repeat (2) @(posedge clk);
        #1 check_idle_outs("reset_held");
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 check_idle_outs("after_release");
        repeat (5) @(posedge clk);
        #1 check("busy_disabled", {31'd0, busy}, 32'd0);

        // First frame
        set_frame(32'd5, 1'b1, 32'h0123_4567);
        enable = 1'b1;
        wait_done("first", 1'b0);
        check("first_latency", 32'(done_cyc - cs_rise_cyc), 32'(6 + 6*NW));
        compare_frame("first");

        // Unchanged counter: idle polling only
        valid_cycles = 0;
        cs_low_cycles = 0;
        c = 32'(done_cnt);
        repeat (200) @(posedge clk);
        #1;
        check("unchanged_valid", 32'(valid_cycles), 32'd0);
        check("unchanged_cs_low", 32'(cs_low_cycles), 32'd80);
        check("unchanged_done", 32'(done_cnt), c);

        // Backpressure on word 2
        set_frame(32'd6 + $urandom_range(0, 1000), 1'b0, 32'd0);
        found = 0;
        for (int n = 0; n < 3000 && found == 0; n++) begin
            @(posedge clk); #1;
            if (word_valid && word_index == 8'd2) found = 1;
        end
        check("bp_found_word2", 32'(found), 32'd1);
        word_ready = 1'b0;
        sa = address;
        sd = word_data;
        si = word_index;
        cs_drops = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!chipselect || !word_valid) cs_drops++;
        end
        check("bp_cs_held", 32'(cs_drops), 32'd0);
        check("bp_address", {16'd0, address}, {16'd0, sa});
        check("bp_word_data", word_data, sd);
        check("bp_word_index", {24'd0, word_index}, {24'd0, si});
        word_ready = 1'b1;
        wait_done("bp", 1'b0);
        compare_frame("bp");

        // Counter wrap
        set_frame(32'hFFFF_FFFF, 1'b0, 32'd0);
        wait_done("wrap_pre", 1'b1);
        compare_frame("wrap_pre");
        set_frame(32'h0000_0000, 1'b0, 32'd0);
        wait_done("wrap", 1'b1);
        compare_frame("wrap");

        // Reset during FETCH of word 1, then the same counter refetched from index 0
        set_frame($urandom | 32'h100, 1'b0, 32'd0);
        found = 0;
        for (int n = 0; n < 3000 && found == 0; n++) begin
            @(posedge clk); #1;
            if (chipselect && !word_valid && word_index == 8'd1) found = 1;
        end
        check("mid_fetch_found", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1 check_idle_outs("mid_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        got_data.delete();
        got_idx.delete();
        wait_done("refetch", 1'b0);
        compare_frame("refetch");

        // After reset, a counter equal to the reset value of last_time is still a first frame
        @(posedge clk); #1 reset = 1'b1;
        set_frame(32'd0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        got_data.delete();
        got_idx.delete();
        wait_done("first_zero", 1'b1);
        compare_frame("first_zero");

        // Dropping enable mid-frame finishes the frame, then goes idle
        set_frame(32'h00C0_FFEE, 1'b0, 32'd0);
        found = 0;
        for (int n = 0; n < 3000 && found == 0; n++) begin
            @(posedge clk); #1;
            if (word_valid) found = 1;
        end
        enable = 1'b0;
        wait_done("disable", 1'b0);
        compare_frame("disable");
        repeat (20) @(posedge clk);
        #1;
        check("disable_busy", {31'd0, busy}, 32'd0);
        check("disable_cs", {31'd0, chipselect}, 32'd0);

        check("valid_hold_stable", 32'(prop_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
